// File: rtl/video_timing_pkg.sv
// Shared presets, RGB packing and total-count helpers for video_timing_gen.
package video_timing_pkg;

    // 640x480@60 (25.175 MHz pixel clock).
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // 256x240 NES picture doubled to 512x480, centred in the 640x480@60 raster.
    localparam int NES_H_ACTIVE = 512;
    localparam int NES_H_FP     = 80;
    localparam int NES_H_SYNC   = 96;
    localparam int NES_H_BP     = 112;
    localparam int NES_V_ACTIVE = 480;
    localparam int NES_V_FP     = 10;
    localparam int NES_V_SYNC   = 2;
    localparam int NES_V_BP     = 33;

    typedef struct packed {
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic line_start;
        logic frame_start;
    } timing_t;

    function automatic int line_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Width/depth parameterised register chain with synchronous reset value; DEPTH 0 is a wire.
module video_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = pclk ^ rst;
            assign q         = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is reset, not just the last one, so no stale
            // pre-reset timing can drain out after rst falls.
            always_ff @(posedge pclk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with sync/blank/strobes aligned to a PIX_LAT-late pixel source.
// Optional post-reset startup hold when VIDEO_TIMING_STARTUP_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit HSYNC_POL      = 1'b0,
    parameter bit VSYNC_POL      = 1'b0,
    parameter int CNT_W          = 11,
    parameter int PIX_LAT        = 1,
    parameter int STARTUP_CYCLES = 3204
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic [23:0]      rgb_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic [23:0]      rgb_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_out,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam timing_t IDLE = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        blank:       1'b1,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [CNT_W-1:0] h, v;
    logic             step;
    timing_t          dec, dly, t_q;
    rgb_t             rgb_q;

`ifdef VIDEO_TIMING_STARTUP_EN
    localparam int SU_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

    logic [SU_W-1:0] su_cnt;
    logic            su_done;

    assign su_done = (su_cnt == SU_W'(STARTUP_CYCLES));

    always_ff @(posedge pclk) begin
        if (rst)           su_cnt <= '0;
        else if (!su_done) su_cnt <= su_cnt + 1'b1;
    end

    assign step = en & su_done;
`else
    assign step = en;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (step) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign x      = h;
    assign y      = v;
    assign active = (h < H_VIS) && (v < V_VIS);

    // NOTE: defaults first so every path assigns every field and no latch forms.
    always_comb begin
        dec             = IDLE;
        dec.hsync       = (h >= HS_BEG && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        dec.vsync       = (v >= VS_BEG && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        dec.blank       = ~active;
        dec.line_start  = (h == '0);
        dec.frame_start = (h == '0) && (v == '0);
    end

    // The decoded bundle waits PIX_LAT cycles so it meets rgb_in of the same x/y,
    // then both are registered together, giving PIX_LAT+1 total latency.
    video_delay_line #(
        .WIDTH   ($bits(timing_t)),
        .DEPTH   (PIX_LAT),
        .RST_VAL (IDLE)
    ) u_delay (
        .pclk (pclk),
        .rst  (rst),
        .d    (dec),
        .q    (dly)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            t_q   <= IDLE;
            rgb_q <= '0;
        end else begin
            t_q   <= dly;
            rgb_q <= dly.blank ? '0 : rgb_t'(rgb_in);
        end
    end

    assign rgb_out     = rgb_q;
    assign hsync_out   = t_q.hsync;
    assign vsync_out   = t_q.vsync;
    assign blank_out   = t_q.blank;
    assign line_start  = t_q.line_start;
    assign frame_start = t_q.frame_start;

endmodule
